// File: rtl/exu_recv_pkg.sv
// Shared definitions for the execute receive stage: ALU op codes, default widths
// and the stage state encoding.
package exu_recv_pkg;

    localparam int EXU_DATA_WIDTH = 32;
    localparam int EXU_ADDR_WIDTH = 32;
    localparam int EXU_ARGS_WIDTH = 8;

    localparam logic [EXU_ARGS_WIDTH-1:0] ALU_TYPE_NOP   = 8'h00;
    localparam logic [EXU_ARGS_WIDTH-1:0] ALU_TYPE_ADD   = 8'h01;
    localparam logic [EXU_ARGS_WIDTH-1:0] ALU_TYPE_SUB   = 8'h02;
    localparam logic [EXU_ARGS_WIDTH-1:0] ALU_TYPE_AND   = 8'h03;
    localparam logic [EXU_ARGS_WIDTH-1:0] ALU_TYPE_OR    = 8'h04;
    localparam logic [EXU_ARGS_WIDTH-1:0] ALU_TYPE_XOR   = 8'h05;
    localparam logic [EXU_ARGS_WIDTH-1:0] ALU_TYPE_SLL   = 8'h06;
    localparam logic [EXU_ARGS_WIDTH-1:0] ALU_TYPE_SRL   = 8'h07;
    localparam logic [EXU_ARGS_WIDTH-1:0] ALU_TYPE_JAL   = 8'h08;
    localparam logic [EXU_ARGS_WIDTH-1:0] ALU_TYPE_LUI   = 8'h09;
    localparam logic [EXU_ARGS_WIDTH-1:0] ALU_TYPE_MUL   = 8'h10;
    localparam logic [EXU_ARGS_WIDTH-1:0] ALU_TYPE_MULHU = 8'h11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } exu_state_e;

    function automatic logic is_mul_op(input logic [EXU_ARGS_WIDTH-1:0] alu_type);
        return (alu_type == ALU_TYPE_MUL) || (alu_type == ALU_TYPE_MULHU);
    endfunction

endpackage

// File: rtl/exu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// full-width product exposed as its next-state value so the final step can be captured directly.
module exu_mul_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      i_sys_clk,
    input  logic                      i_sys_rst,
    input  logic                      i_start,
    input  logic [DATA_WIDTH-1:0]     i_mcand,
    input  logic [DATA_WIDTH-1:0]     i_mplier,
    output logic                      o_done,
    output logic [2*DATA_WIDTH-1:0]   o_product
);

    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic [PROD_WIDTH-1:0] product_reg;
    logic [PROD_WIDTH-1:0] product_next;
    logic [DATA_WIDTH-1:0] mcand_reg;
    logic [DATA_WIDTH-1:0] mplier_reg;
    logic                  busy_reg;
    logic [DATA_WIDTH:0]   addend;
    logic [DATA_WIDTH:0]   sum;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate
    assign addend[DATA_WIDTH] = 1'b0;

    // The carry out of the upper-half add becomes the new MSB after the shift.
    assign sum          = {1'b0, product_reg[PROD_WIDTH-1:DATA_WIDTH]} + addend;
    assign product_next = PROD_WIDTH'({sum, product_reg[DATA_WIDTH-1:0]} >> 1);

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            cnt_reg     <= '0;
            product_reg <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            busy_reg    <= 1'b0;
        end else if (i_start) begin
            cnt_reg     <= '0;
            product_reg <= '0;
            mcand_reg   <= i_mcand;
            mplier_reg  <= i_mplier;
            busy_reg    <= 1'b1;
        end else if (busy_reg) begin
            product_reg <= product_next;
            mplier_reg  <= mplier_reg >> 1;
            cnt_reg     <= cnt_reg + CNT_WIDTH'(1);
            if (cnt_reg == CNT_LAST) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign o_done    = busy_reg && (cnt_reg == CNT_LAST);
    assign o_product = product_next;

endmodule

// File: rtl/exu_recv.sv
// Execute receive stage: accepts one decoded bundle, returns bypass data or a multiply result.
// Optional multiplier enabled by defining EXU_RECV_MUL_EN; otherwise MUL/MULHU return 0.
module exu_recv
    import exu_recv_pkg::*;
#(
    parameter int DATA_WIDTH = EXU_DATA_WIDTH,
    parameter int ADDR_WIDTH = EXU_ADDR_WIDTH,
    parameter int ARGS_WIDTH = EXU_ARGS_WIDTH
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_idu_valid,
    output logic                  o_idu_ready,
    input  logic [ADDR_WIDTH-1:0] i_idu_pc,
    input  logic [ARGS_WIDTH-1:0] i_idu_ctr_alu_type,
    input  logic                  i_idu_ctr_reg_wr_en,
    input  logic [DATA_WIDTH-1:0] i_idu_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_idu_rs2_data,
    input  logic [DATA_WIDTH-1:0] i_idu_jmp_or_reg_data,
    output logic                  o_exu_valid,
    input  logic                  i_lsu_ready,
    output logic [ADDR_WIDTH-1:0] o_exu_pc,
    output logic [DATA_WIDTH-1:0] o_exu_res,
    output logic                  o_exu_reg_wr_en
);

    exu_state_e            state_reg;
    exu_state_e            state_next;
    logic                  accept;
    logic                  in_is_mul;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] res_reg;
    logic                  wr_en_reg;

    assign in_is_mul = is_mul_op(EXU_ARGS_WIDTH'(i_idu_ctr_alu_type));

`ifdef EXU_RECV_MUL_EN
    logic                    mul_start;
    logic                    mul_done;
    logic [2*DATA_WIDTH-1:0] mul_product;
    logic [ARGS_WIDTH-1:0]   alu_type_reg;

    assign mul_start = accept && in_is_mul;

    exu_mul_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul_iter (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .i_start   (mul_start),
        .i_mcand   (i_idu_rs1_data),
        .i_mplier  (i_idu_rs2_data),
        .o_done    (mul_done),
        .o_product (mul_product)
    );
`else
    logic unused_operands;
    assign unused_operands = ^{i_idu_rs1_data, i_idu_rs2_data};
`endif

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        o_idu_ready = 1'b0;
        o_exu_valid = 1'b0;
        accept      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                o_idu_ready = 1'b1;
                if (i_idu_valid) begin
                    accept = 1'b1;
`ifdef EXU_RECV_MUL_EN
                    state_next = in_is_mul ? ST_BUSY : ST_DONE;
`else
                    state_next = ST_DONE;
`endif
                end
            end
            ST_BUSY: begin
`ifdef EXU_RECV_MUL_EN
                if (mul_done) begin
                    state_next = ST_DONE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            ST_DONE: begin
                o_exu_valid = 1'b1;
                if (i_lsu_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A multiply leaves the previous result visible until its final step lands.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            pc_reg       <= '0;
            res_reg      <= '0;
            wr_en_reg    <= 1'b0;
`ifdef EXU_RECV_MUL_EN
            alu_type_reg <= '0;
`endif
        end else if (accept) begin
            pc_reg    <= i_idu_pc;
            wr_en_reg <= i_idu_ctr_reg_wr_en;
`ifdef EXU_RECV_MUL_EN
            alu_type_reg <= i_idu_ctr_alu_type;
            if (!in_is_mul) begin
                res_reg <= i_idu_jmp_or_reg_data;
            end
`else
            res_reg <= in_is_mul ? '0 : i_idu_jmp_or_reg_data;
`endif
        end
`ifdef EXU_RECV_MUL_EN
        else if ((state_reg == ST_BUSY) && mul_done) begin
            res_reg <= (alu_type_reg == ARGS_WIDTH'(ALU_TYPE_MULHU))
                     ? mul_product[2*DATA_WIDTH-1:DATA_WIDTH]
                     : mul_product[DATA_WIDTH-1:0];
        end
`endif
    end

    assign o_exu_pc        = pc_reg;
    assign o_exu_res       = res_reg;
    assign o_exu_reg_wr_en = wr_en_reg;

endmodule

// File: tb/tb_exu_recv.sv
// Scoreboard bench for exu_recv: driver pushes expected results, a negedge monitor pops and compares.
module tb_exu_recv;
    import exu_recv_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int GW = 8;

    logic          i_sys_clk = 1'b0;
    logic          i_sys_rst = 1'b1;
    logic          i_idu_valid = 1'b0;
    logic          o_idu_ready;
    logic [AW-1:0] i_idu_pc = '0;
    logic [GW-1:0] i_idu_ctr_alu_type = '0;
    logic          i_idu_ctr_reg_wr_en = 1'b0;
    logic [DW-1:0] i_idu_rs1_data = '0;
    logic [DW-1:0] i_idu_rs2_data = '0;
    logic [DW-1:0] i_idu_jmp_or_reg_data = '0;
    logic          o_exu_valid;
    logic          i_lsu_ready = 1'b0;
    logic [AW-1:0] o_exu_pc;
    logic [DW-1:0] o_exu_res;
    logic          o_exu_reg_wr_en;

    always #5 i_sys_clk = ~i_sys_clk;

    int cyc = 0;
    always @(posedge i_sys_clk) cyc <= cyc + 1;

    exu_recv #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ARGS_WIDTH (GW)
    ) dut (
        .i_sys_clk             (i_sys_clk),
        .i_sys_rst             (i_sys_rst),
        .i_idu_valid           (i_idu_valid),
        .o_idu_ready           (o_idu_ready),
        .i_idu_pc              (i_idu_pc),
        .i_idu_ctr_alu_type    (i_idu_ctr_alu_type),
        .i_idu_ctr_reg_wr_en   (i_idu_ctr_reg_wr_en),
        .i_idu_rs1_data        (i_idu_rs1_data),
        .i_idu_rs2_data        (i_idu_rs2_data),
        .i_idu_jmp_or_reg_data (i_idu_jmp_or_reg_data),
        .o_exu_valid           (o_exu_valid),
        .i_lsu_ready           (i_lsu_ready),
        .o_exu_pc              (o_exu_pc),
        .o_exu_res             (o_exu_res),
        .o_exu_reg_wr_en       (o_exu_reg_wr_en)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] res;
        logic          wr;
        int            lat;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_txn = 0;
    int   hold_left = 0;
    bit   garbage_en = 1'b0;
    bit   lsu_always = 1'b0;

    logic [GW-1:0] ops [10] = '{ALU_TYPE_ADD, ALU_TYPE_SUB, ALU_TYPE_AND, ALU_TYPE_XOR,
                                ALU_TYPE_JAL, ALU_TYPE_LUI, ALU_TYPE_MUL, ALU_TYPE_MULHU,
                                ALU_TYPE_MUL, ALU_TYPE_MULHU};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
    endtask

    // Unsigned full-precision product, or zero when the multiplier is not built.
    function automatic logic [DW-1:0] model_res(input logic [GW-1:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b, input logic [DW-1:0] byp);
`ifdef EXU_RECV_MUL_EN
        logic [2*DW-1:0] full;
        logic [DW-1:0]   lo;
        logic [DW-1:0]   hi;
        full = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        lo = full[DW-1:0];
        hi = full[2*DW-1:DW];
        if (op == ALU_TYPE_MUL) return lo;
        if (op == ALU_TYPE_MULHU) return hi;
`else
        if (op == ALU_TYPE_MUL || op == ALU_TYPE_MULHU) return '0;
`endif
        return byp;
    endfunction

    function automatic int model_lat(input logic [GW-1:0] op);
`ifdef EXU_RECV_MUL_EN
        if (op == ALU_TYPE_MUL || op == ALU_TYPE_MULHU) return 33;
`endif
        return 1;
    endfunction

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic idle_drive();
        i_idu_valid           = garbage_en && !o_idu_ready && ($urandom_range(0, 1) == 1);
        i_idu_pc              = AW'($urandom);
        i_idu_ctr_alu_type    = ops[$urandom_range(0, 9)];
        i_idu_ctr_reg_wr_en   = 1'($urandom_range(0, 1));
        i_idu_rs1_data        = DW'($urandom);
        i_idu_rs2_data        = DW'($urandom);
        i_idu_jmp_or_reg_data = DW'($urandom);
        if (o_exu_valid && hold_left > 0) begin
            i_lsu_ready = 1'b0;
            hold_left--;
        end else begin
            i_lsu_ready = lsu_always ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send(input logic [GW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] byp, input logic [AW-1:0] pc, input logic wr,
                        input int hold);
        int   guard;
        exp_t e;
        guard = 0;
        while (!o_idu_ready) begin
            if (guard > 300) begin
                timeout_fail("wait_ready");
                return;
            end
            guard++;
            idle_drive();
            @(posedge i_sys_clk);
            #1;
        end
        i_idu_valid           = 1'b1;
        i_idu_pc              = pc;
        i_idu_ctr_alu_type    = op;
        i_idu_ctr_reg_wr_en   = wr;
        i_idu_rs1_data        = a;
        i_idu_rs2_data        = b;
        i_idu_jmp_or_reg_data = byp;
        i_lsu_ready           = lsu_always ? 1'b1 : 1'($urandom_range(0, 1));
        e.pc  = pc;
        e.res = model_res(op, a, b, byp);
        e.wr  = wr;
        e.lat = model_lat(op);
        e.acc = cyc;
        exp_q.push_back(e);
        hold_left = hold;
        @(posedge i_sys_clk);
        #1;
        i_idu_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0) begin
            if (guard > 300) begin
                timeout_fail("drain");
                exp_q.delete();
                break;
            end
            guard++;
            idle_drive();
            @(posedge i_sys_clk);
            #1;
        end
        idle_drive();
        @(posedge i_sys_clk);
        #1;
    endtask

    // Monitor: compares every presented result against the head of the scoreboard.
    bit   mon_seen = 1'b0;
    bit   mon_post = 1'b0;
    exp_t mon_e;
    always @(negedge i_sys_clk) begin
        if (i_sys_rst) begin
            mon_seen = 1'b0;
            mon_post = 1'b0;
        end else begin
            if (mon_post) begin
                check("idle_ready_after_handoff", 64'(o_idu_ready), 64'd1);
                check("no_back_to_back_valid", 64'(o_exu_valid), 64'd0);
                mon_post = 1'b0;
            end
            if (o_exu_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: o_exu_valid=1 res=0x%0h with no pending transaction", o_exu_res);
                end else begin
                    mon_e = exp_q[0];
                    if (!mon_seen) begin
                        check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                        mon_seen = 1'b1;
                    end
                    check("res", 64'(o_exu_res), 64'(mon_e.res));
                    check("pc", 64'(o_exu_pc), 64'(mon_e.pc));
                    check("reg_wr_en", 64'(o_exu_reg_wr_en), 64'(mon_e.wr));
                    check("ready_low_in_done", 64'(o_idu_ready), 64'd0);
                    if (i_lsu_ready) begin
                        n_txn++;
                        $display("txn %0d: pc=0x%08h res=0x%08h wr_en=%0d lat=%0d", n_txn,
                                 o_exu_pc, o_exu_res, o_exu_reg_wr_en, cyc - mon_e.acc);
                        void'(exp_q.pop_front());
                        mon_seen = 1'b0;
                        mon_post = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        i_sys_rst = 1'b1;
        repeat (3) @(posedge i_sys_clk);
        #1;
        i_sys_rst = 1'b0;
        check("reset_pc", 64'(o_exu_pc), 64'd0);
        check("reset_res", 64'(o_exu_res), 64'd0);
        check("reset_wr_en", 64'(o_exu_reg_wr_en), 64'd0);
        check("reset_valid", 64'(o_exu_valid), 64'd0);
        check("reset_ready", 64'(o_idu_ready), 64'd1);

        lsu_always = 1'b1;
        send(ALU_TYPE_ADD, 32'h1111_1111, 32'h2222_2222, 32'h1234_5678, 32'h0000_1000, 1'b1, 0);
        send(ALU_TYPE_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h0000_1004, 1'b1, 0);
        send(ALU_TYPE_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 32'h0000_1008, 1'b0, 0);
        lsu_always = 1'b0;
        send(ALU_TYPE_MUL, 32'd7, 32'd6, 32'hDEAD_BEEF, 32'h0000_100C, 1'b1, 10);
        garbage_en = 1'b1;
        send(ALU_TYPE_MULHU, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h0, 32'h0000_1010, 1'b1, 0);
        send(ALU_TYPE_MUL, 32'h0001_3579, 32'h0000_2468, 32'h0, 32'h0000_1014, 1'b0, 0);
        garbage_en = 1'b0;
        send(ALU_TYPE_MULHU, 32'h0, 32'hFFFF_FFFF, 32'h7777_7777, 32'h0000_1018, 1'b1, 0);
        send(ALU_TYPE_XOR, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0000_101C, 1'b1, 3);
        drain();

        // Abort an operation in flight, then confirm a fresh multiply is clean.
        send(ALU_TYPE_MUL, 32'h0000_DEAD, 32'h0000_1234, 32'h0, 32'h0000_2000, 1'b1, 1000);
`ifdef EXU_RECV_MUL_EN
        repeat (14) begin
`else
        repeat (2) begin
`endif
            idle_drive();
            @(posedge i_sys_clk);
            #1;
        end
        i_sys_rst   = 1'b1;
        i_idu_valid = 1'b0;
        exp_q.delete();
        hold_left = 0;
        @(posedge i_sys_clk);
        #1;
        i_sys_rst = 1'b0;
        check("abort_pc", 64'(o_exu_pc), 64'd0);
        check("abort_res", 64'(o_exu_res), 64'd0);
        check("abort_wr_en", 64'(o_exu_reg_wr_en), 64'd0);
        check("abort_valid", 64'(o_exu_valid), 64'd0);
        check("abort_ready", 64'(o_idu_ready), 64'd1);
        send(ALU_TYPE_MUL, 32'd3, 32'd5, 32'h9999_9999, 32'h0000_2004, 1'b1, 0);
        drain();

        for (int i = 0; i < 40; i++) begin
            garbage_en = ($urandom_range(0, 1) == 1);
            lsu_always = ($urandom_range(0, 3) == 0);
            send(ops[$urandom_range(0, 9)], pick_operand(), pick_operand(), DW'($urandom),
                 AW'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
        end
        garbage_en = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
